// File: rtl/ct_mmu_pkg.sv
// Shared types and default widths for the data-uTLB refill controller.
package ct_mmu_pkg;

    localparam int unsigned CT_ENTRY_NUM = 16;
    localparam int unsigned CT_VPN_WIDTH = 27;
    localparam int unsigned CT_PPN_WIDTH = 28;
    localparam int unsigned CT_FLG_WIDTH = 14;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        FILL  = 3'd4
    } refill_state_t;

endpackage

// File: rtl/ct_mmu_dutlb_victim_sel.sv
// Victim selection: first invalid entry, otherwise the round-robin pointer.
module ct_mmu_dutlb_victim_sel #(
    parameter int unsigned ENTRY_NUM = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [ENTRY_NUM-1:0] i_entry_vld,
    input  logic                 i_ptr_adv,
    output logic [ENTRY_NUM-1:0] o_victim,
    output logic                 o_use_rr
);

    localparam int unsigned PTR_W = $clog2(ENTRY_NUM);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(ENTRY_NUM - 1);

    logic [PTR_W-1:0]     r_ptr;
    logic [ENTRY_NUM-1:0] w_first_inv;
    logic                 w_found;
    logic [ENTRY_NUM-1:0] w_rr_onehot;

    // Lowest-index invalid entry, one-hot
    always_comb begin
        w_first_inv = '0;
        w_found     = 1'b0;
        for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            if (!i_entry_vld[i] && !w_found) begin
                w_first_inv[i] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    // Decode the round-robin pointer to one-hot
    always_comb begin
        w_rr_onehot        = '0;
        w_rr_onehot[r_ptr] = 1'b1;
    end

    assign o_victim = w_found ? w_first_inv : w_rr_onehot;
    assign o_use_rr = ~w_found;

    // Round-robin pointer, wraps ENTRY_NUM-1 -> 0
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_ptr_adv) begin
            r_ptr <= (r_ptr == PTR_MAX) ? '0 : r_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ct_mmu_dutlb_refill.sv
// Data-uTLB refill controller: miss detect, JTLB request/response, victim write.
module ct_mmu_dutlb_refill
    import ct_mmu_pkg::*;
#(
    parameter int unsigned ENTRY_NUM = CT_ENTRY_NUM,
    parameter int unsigned VPN_WIDTH = CT_VPN_WIDTH,
    parameter int unsigned PPN_WIDTH = CT_PPN_WIDTH,
    parameter int unsigned FLG_WIDTH = CT_FLG_WIDTH
) (
    input  logic                 utlb_clk,
    input  logic                 cpurst,
    input  logic                 lsu_utlb_req_vld,
    input  logic [VPN_WIDTH-1:0] lsu_utlb_req_vpn,
    input  logic [ENTRY_NUM-1:0] utlb_entry_vld,
    input  logic [ENTRY_NUM-1:0] utlb_entry_hit,
    input  logic                 utlb_clr,
    output logic                 utlb_jtlb_req,
    output logic [VPN_WIDTH-1:0] utlb_jtlb_vpn,
    input  logic                 jtlb_utlb_grant,
    input  logic                 jtlb_utlb_resp_vld,
    input  logic [PPN_WIDTH-1:0] jtlb_utlb_resp_ppn,
    input  logic [FLG_WIDTH-1:0] jtlb_utlb_resp_flg,
    input  logic                 jtlb_utlb_resp_flt,
    output logic [ENTRY_NUM-1:0] utlb_entry_upd,
    output logic [VPN_WIDTH-1:0] utlb_upd_vpn,
    output logic [PPN_WIDTH-1:0] utlb_upd_ppn,
    output logic [FLG_WIDTH-1:0] utlb_upd_flg,
    output logic                 utlb_refill_busy,
    output logic                 utlb_refill_fault
);

    refill_state_t        r_state;
    refill_state_t        w_state_nxt;
    logic [VPN_WIDTH-1:0] r_vpn;
    logic [PPN_WIDTH-1:0] r_ppn;
    logic [FLG_WIDTH-1:0] r_flg;
    logic [ENTRY_NUM-1:0] r_victim;
    logic                 r_victim_rr;
    logic                 r_fault;

    logic                 w_miss;
    logic                 w_accept;
    logic                 w_resp_ok;
    logic                 w_resp_flt;
    logic [ENTRY_NUM-1:0] w_victim;
    logic                 w_use_rr;
    logic                 w_ptr_adv;

    assign w_miss     = lsu_utlb_req_vld & ~|(utlb_entry_vld & utlb_entry_hit);
    assign w_accept   = (r_state == IDLE) & w_miss & ~utlb_clr;
    assign w_resp_ok  = (r_state == WAIT) & jtlb_utlb_resp_vld & ~jtlb_utlb_resp_flt & ~utlb_clr;
    assign w_resp_flt = (r_state == WAIT) & jtlb_utlb_resp_vld & jtlb_utlb_resp_flt;
    assign w_ptr_adv  = (r_state == FILL) & r_victim_rr;

    ct_mmu_dutlb_victim_sel #(
        .ENTRY_NUM (ENTRY_NUM)
    ) u_victim_sel (
        .i_clk       (utlb_clk),
        .i_rst       (cpurst),
        .i_entry_vld (utlb_entry_vld),
        .i_ptr_adv   (w_ptr_adv),
        .o_victim    (w_victim),
        .o_use_rr    (w_use_rr)
    );

    // State register
    always_ff @(posedge utlb_clk or posedge cpurst) begin
        if (cpurst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (jtlb_utlb_grant && utlb_clr) begin
                    w_state_nxt = DRAIN;
                end else if (jtlb_utlb_grant) begin
                    w_state_nxt = WAIT;
                end else if (utlb_clr) begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (w_resp_ok) begin
                    w_state_nxt = FILL;
                end else if (jtlb_utlb_resp_vld) begin
                    w_state_nxt = IDLE;
                end else if (utlb_clr) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (jtlb_utlb_resp_vld) begin
                    w_state_nxt = IDLE;
                end
            end
            FILL: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Capture lookup VPN, response data, victim and fault pulse
    always_ff @(posedge utlb_clk or posedge cpurst) begin
        if (cpurst) begin
            r_vpn       <= '0;
            r_ppn       <= '0;
            r_flg       <= '0;
            r_victim    <= '0;
            r_victim_rr <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_fault <= w_resp_flt;
            if (w_accept) begin
                r_vpn <= lsu_utlb_req_vpn;
            end
            if (w_resp_ok) begin
                r_ppn       <= jtlb_utlb_resp_ppn;
                r_flg       <= jtlb_utlb_resp_flg;
                r_victim    <= w_victim;
                r_victim_rr <= w_use_rr;
            end
        end
    end

    assign utlb_jtlb_req     = (r_state == REQ);
    assign utlb_jtlb_vpn     = r_vpn;
    assign utlb_refill_busy  = (r_state != IDLE);
    assign utlb_refill_fault = r_fault;
    assign utlb_entry_upd    = ((r_state == FILL) && !utlb_clr) ? r_victim : '0;
    assign utlb_upd_vpn      = r_vpn;
    assign utlb_upd_ppn      = r_ppn;
    assign utlb_upd_flg      = r_flg;

endmodule

// File: tb/tb_ct_mmu_dutlb_refill.sv
// Directed self-checking bench for the data-uTLB refill controller.
module tb_ct_mmu_dutlb_refill;

    localparam int unsigned EN = 16;
    localparam int unsigned VW = 27;
    localparam int unsigned PW = 28;
    localparam int unsigned FW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_vld;
    logic [VW-1:0] req_vpn;
    logic [EN-1:0] ent_vld;
    logic [EN-1:0] ent_hit;
    logic          clr;
    logic          jreq;
    logic [VW-1:0] jvpn;
    logic          grant;
    logic          rvld;
    logic [PW-1:0] rppn;
    logic [FW-1:0] rflg;
    logic          rflt;
    logic [EN-1:0] upd;
    logic [VW-1:0] uvpn;
    logic [PW-1:0] uppn;
    logic [FW-1:0] uflg;
    logic          busy;
    logic          fault;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ct_mmu_dutlb_refill #(
        .ENTRY_NUM (EN),
        .VPN_WIDTH (VW),
        .PPN_WIDTH (PW),
        .FLG_WIDTH (FW)
    ) dut (
        .utlb_clk           (clk),
        .cpurst             (rst),
        .lsu_utlb_req_vld   (req_vld),
        .lsu_utlb_req_vpn   (req_vpn),
        .utlb_entry_vld     (ent_vld),
        .utlb_entry_hit     (ent_hit),
        .utlb_clr           (clr),
        .utlb_jtlb_req      (jreq),
        .utlb_jtlb_vpn      (jvpn),
        .jtlb_utlb_grant    (grant),
        .jtlb_utlb_resp_vld (rvld),
        .jtlb_utlb_resp_ppn (rppn),
        .jtlb_utlb_resp_flg (rflg),
        .jtlb_utlb_resp_flt (rflt),
        .utlb_entry_upd     (upd),
        .utlb_upd_vpn       (uvpn),
        .utlb_upd_ppn       (uppn),
        .utlb_upd_flg       (uflg),
        .utlb_refill_busy   (busy),
        .utlb_refill_fault  (fault)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Miss -> REQ -> grant -> WAIT -> resp -> FILL, checking the write pulse
    task automatic refill(input string tag, input logic [EN-1:0] vld, input logic [VW-1:0] vpn,
                          input logic [PW-1:0] ppn, input logic [FW-1:0] flg,
                          input logic [EN-1:0] exp_upd);
        ent_vld = vld;
        ent_hit = '0;
        req_vld = 1'b1;
        req_vpn = vpn;
        tick();
        req_vld = 1'b0;
        chk({tag, "_req"}, 64'(jreq), 64'd1);
        chk({tag, "_jvpn"}, 64'(jvpn), 64'(vpn));
        grant = 1'b1;
        tick();
        grant = 1'b0;
        chk({tag, "_wait_noreq"}, 64'(jreq), 64'd0);
        rvld = 1'b1;
        rppn = ppn;
        rflg = flg;
        rflt = 1'b0;
        tick();
        rvld = 1'b0;
        chk({tag, "_upd"}, 64'(upd), 64'(exp_upd));
        chk({tag, "_uvpn"}, 64'(uvpn), 64'(vpn));
        chk({tag, "_uppn"}, 64'(uppn), 64'(ppn));
        chk({tag, "_uflg"}, 64'(uflg), 64'(flg));
        tick();
        chk({tag, "_upd_1cyc"}, 64'(upd), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst     = 1'b1;
        req_vld = 1'b0;
        req_vpn = '0;
        ent_vld = '0;
        ent_hit = '0;
        clr     = 1'b0;
        grant   = 1'b0;
        rvld    = 1'b0;
        rppn    = '0;
        rflg    = '0;
        rflt    = 1'b0;
        #23;
        // Reset state
        chk("rst_req", 64'(jreq), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_upd", 64'(upd), 64'd0);
        chk("rst_jvpn", 64'(jvpn), 64'd0);
        chk("rst_uppn", 64'(uppn), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Hit: no request
        ent_vld = 16'h0004;
        ent_hit = 16'h0004;
        req_vld = 1'b1;
        req_vpn = 27'h00777;
        tick();
        req_vld = 1'b0;
        chk("hit_noreq", 64'(jreq), 64'd0);
        chk("hit_nobusy", 64'(busy), 64'd0);
        // Valid but non-hit entry still misses
        ent_hit = 16'h0008;
        req_vld = 1'b1;
        tick();
        req_vld = 1'b0;
        chk("hit_otherent_req", 64'(jreq), 64'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("req_clr_idle", 64'(busy), 64'd0);
        ent_hit = '0;

        // Cold miss
        refill("cold", 16'h0000, 27'h12345, 28'hABCDE, 14'h3F, 16'h0001);

        // Full array: rr walks 0..15 then wraps to 0
        for (int k = 0; k < 16; k++) begin
            refill($sformatf("full%0d", k), 16'hFFFF, VW'(27'h100 + k), PW'(28'h2000 + k),
                   FW'(k), EN'(16'h0001 << k));
        end
        refill("wrap", 16'hFFFF, 27'h1F00, 28'h3F00, 14'h1, 16'h0001);

        // Hole fill does not move rr (rr is now 1)
        refill("hole", 16'hFFEF, 27'h0ABC, 28'h0DEF, 14'h2A, 16'h0010);
        refill("after_hole", 16'hFFFF, 27'h0ABD, 28'h0DF0, 14'h2B, 16'h0002);

        // Fault response
        ent_vld = '0;
        req_vld = 1'b1;
        req_vpn = 27'h4444;
        tick();
        req_vld = 1'b0;
        grant = 1'b1;
        tick();
        grant = 1'b0;
        rvld = 1'b1;
        rflt = 1'b1;
        tick();
        rvld = 1'b0;
        rflt = 1'b0;
        chk("flt_pulse", 64'(fault), 64'd1);
        chk("flt_noupd", 64'(upd), 64'd0);
        chk("flt_busy", 64'(busy), 64'd0);
        tick();
        chk("flt_pulse_1cyc", 64'(fault), 64'd0);

        // Flush in WAIT -> DRAIN; late response discarded
        req_vld = 1'b1;
        req_vpn = 27'h5555;
        tick();
        req_vld = 1'b0;
        grant = 1'b1;
        tick();
        grant = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_noreq", 64'(jreq), 64'd0);
        tick();
        tick();
        rvld = 1'b1;
        rppn = 28'h1234;
        tick();
        rvld = 1'b0;
        chk("drain_noupd", 64'(upd), 64'd0);
        chk("drain_nofault", 64'(fault), 64'd0);
        chk("drain_idle", 64'(busy), 64'd0);
        tick();
        chk("drain_noupd2", 64'(upd), 64'd0);

        // Flush in FILL -> zero pulse
        req_vld = 1'b1;
        req_vpn = 27'h6666;
        tick();
        req_vld = 1'b0;
        grant = 1'b1;
        tick();
        grant = 1'b0;
        rvld = 1'b1;
        tick();
        rvld = 1'b0;
        chk("fill_busy", 64'(busy), 64'd1);
        clr = 1'b1;
        #1;
        chk("fillclr_upd", 64'(upd), 64'd0);
        tick();
        clr = 1'b0;
        chk("fillclr_idle", 64'(busy), 64'd0);

        // Second miss while busy ignored
        req_vld = 1'b1;
        req_vpn = 27'h7001;
        tick();
        req_vpn = 27'h7002;
        tick();
        chk("busy_jvpn_hold", 64'(jvpn), 64'h7001);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        req_vpn = 27'h7003;
        tick();
        chk("busy_wait_noreq", 64'(jreq), 64'd0);
        rvld = 1'b1;
        rppn = 28'h9999;
        tick();
        rvld = 1'b0;
        req_vld = 1'b0;
        chk("busy_upd", 64'(upd), 64'h0001);
        chk("busy_uvpn", 64'(uvpn), 64'h7001);
        tick();
        chk("busy_done_noreq", 64'(jreq), 64'd0);
        chk("busy_done_idle", 64'(busy), 64'd0);

        // Reset mid-operation
        req_vld = 1'b1;
        req_vpn = 27'h0808;
        tick();
        req_vld = 1'b0;
        chk("mid_req", 64'(jreq), 64'd1);
        rst = 1'b1;
        #2;
        chk("mid_rst_req", 64'(jreq), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_jvpn", 64'(jvpn), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("mid_rst_upd", 64'(upd), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
